tristate_bus_xcvr: RTL and testbench

//  Half-duplex port onto a shared tri-state bus: the receiving/driving counterpart to the codebase's

---
 rtl/tristate_bus_pkg.sv | 29 ++
 rtl/tri_buf.sv | 24 ++
 rtl/tristate_bus_xcvr.sv | 196 +++++++++++++++++++
 tb/tb_tristate_bus_xcvr.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tristate_bus_pkg.sv
// ----------------------------------------------------------------------------
// tristate_bus_pkg
//   Shared definitions for the tri-state bus transceiver:
//     - xcvr_state_e        : transmit FSM state encoding
//     - DEFAULT_WIDTH       : default data/bus width
//     - DEFAULT_TURN_CYCLES : default bus-release cycles after a transmit
//     - turn_cnt_width()    : width of the turn-around counter for a given
//                             TURN_CYCLES value
// ----------------------------------------------------------------------------
package tristate_bus_pkg;

  localparam int DEFAULT_WIDTH       = 8;
  localparam int DEFAULT_TURN_CYCLES = 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    HOLD   = 3'd3,
    TURN   = 3'd4
  } xcvr_state_e;

  // The turn counter runs 0 .. turn_cycles-1, so it needs clog2(turn_cycles)
  // bits, but never fewer than one.
  function automatic int turn_cnt_width(input int turn_cycles);
    return (turn_cycles <= 1) ? 1 : $clog2(turn_cycles);
  endfunction

endpackage

// File: rtl/tri_buf.sv
// ----------------------------------------------------------------------------
// tri_buf
//   WIDTH-bit array of bufif1 primitives. Each io bit follows in_i while en_i
//   is high and is released (Z) while en_i is low.
//   Ports:
//     in_i  [WIDTH-1:0]  value to drive
//     en_i               drive enable (shared by all bits)
//     io_io [WIDTH-1:0]  tri-state net being driven
// ----------------------------------------------------------------------------
module tri_buf #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] in_i,
  input  logic             en_i,
  inout  wire  [WIDTH-1:0] io_io
);

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_buf
      bufif1 u_bufif1 (io_io[gi], in_i[gi], en_i);
    end
  endgenerate

endmodule

// File: rtl/tristate_bus_xcvr.sv
// ----------------------------------------------------------------------------
// tristate_bus_xcvr
//   Half-duplex port onto a shared tri-state bus with one peer. A word taken
//   from the local valid/ready source is placed on bus_io for three cycles
//   (SETUP, STROBE, HOLD) with stb_io high in the middle one; the bus is then
//   released for TURN_CYCLES cycles before another word can be accepted.
//   While this block is not driving, a rising peer strobe captures bus_io
//   into rx_data and pulses rx_valid for one cycle.
//
//   Parameters:
//     WIDTH        data / bus width
//     TURN_CYCLES  bus-release cycles after each transmit (>= 1)
//   Ports:
//     clk, rst_n           clock (rising edge), async active-low reset
//     tx_data/tx_valid     word to send and its valid
//     tx_ready             block accepts tx_data this cycle
//     rx_data/rx_valid     last captured peer word, one-cycle update pulse
//     bus_io, stb_io       shared data bus and strobe (external nets tri0)
//     oe                   1 while this block drives bus_io/stb_io
//   Optional feature (define BUS_PARITY_EN):
//     par_io               even parity over data, driven alongside bus_io
//     rx_parity_err        pulses with rx_valid when the captured parity
//                          does not match the captured data
// ----------------------------------------------------------------------------
module tristate_bus_xcvr
  import tristate_bus_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int TURN_CYCLES = DEFAULT_TURN_CYCLES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  inout  wire  [WIDTH-1:0] bus_io,
  inout  wire              stb_io,
`ifdef BUS_PARITY_EN
  inout  wire              par_io,
  output logic             rx_parity_err,
`endif
  output logic             oe
);

  localparam int               CNT_W     = turn_cnt_width(TURN_CYCLES);
  localparam logic [CNT_W-1:0] TURN_LAST = CNT_W'(TURN_CYCLES - 1);

  xcvr_state_e      state_q,    state_d;
  logic [CNT_W-1:0] turn_cnt_q, turn_cnt_d;
  logic [WIDTH-1:0] tx_word_q,  tx_word_d;
  logic             stb_prev_q;
  logic [WIDTH-1:0] rx_data_q;
  logic             rx_valid_q;

  logic drive_en;
  logic stb_drive;
  logic peer_stb;
  logic capture;

  // --------------------------------------------------------------------------
  // Drive controls depend on the registered state only, so the async reset
  // releases the bus in the same instant it returns state_q to IDLE.
  // --------------------------------------------------------------------------
  always_comb begin
    drive_en  = 1'b0;
    stb_drive = 1'b0;
    case (state_q)
      SETUP:   drive_en = 1'b1;
      STROBE: begin
        drive_en  = 1'b1;
        stb_drive = 1'b1;
      end
      HOLD:    drive_en = 1'b1;
      default: ;
    endcase
  end

  // Only a definite 1 counts as a strobe; X/Z on the line reads as idle.
  // Our own strobe is masked so a transmit is never captured locally.
  assign peer_stb = (stb_io === 1'b1) && !drive_en;
  assign capture  = peer_stb && !stb_prev_q;

  // A peer strobe in IDLE takes priority: tx is held off that cycle.
  assign tx_ready = rst_n && (state_q == IDLE) && !peer_stb;

  // --------------------------------------------------------------------------
  // Transmit FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    turn_cnt_d = turn_cnt_q;
    tx_word_d  = tx_word_q;
    case (state_q)
      IDLE: begin
        if (tx_valid && tx_ready) begin
          tx_word_d = tx_data;
          state_d   = SETUP;
        end
      end
      SETUP:  state_d = STROBE;
      STROBE: state_d = HOLD;
      HOLD: begin
        state_d    = TURN;
        turn_cnt_d = '0;
      end
      TURN: begin
        if (turn_cnt_q == TURN_LAST) begin
          state_d    = IDLE;
          turn_cnt_d = '0;
        end else begin
          turn_cnt_d = turn_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d    = IDLE;
        turn_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      turn_cnt_q <= '0;
      tx_word_q  <= '0;
    end else begin
      state_q    <= state_d;
      turn_cnt_q <= turn_cnt_d;
      tx_word_q  <= tx_word_d;
    end
  end

  // --------------------------------------------------------------------------
  // Receive: capture on the first cycle of a peer strobe only, so a strobe
  // held for several cycles yields a single rx_valid pulse.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stb_prev_q <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      stb_prev_q <= peer_stb;
      rx_valid_q <= capture;
      if (capture) begin
        rx_data_q <= bus_io;
      end
    end
  end

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign oe       = drive_en;

  // --------------------------------------------------------------------------
  // Bus drivers
  // --------------------------------------------------------------------------
  tri_buf #(.WIDTH(WIDTH)) u_bus_buf (
    .in_i  (tx_word_q),
    .en_i  (drive_en),
    .io_io (bus_io)
  );

  tri_buf #(.WIDTH(1)) u_stb_buf (
    .in_i  (stb_drive),
    .en_i  (drive_en),
    .io_io (stb_io)
  );

`ifdef BUS_PARITY_EN
  logic par_drive;
  logic rx_parity_err_q;

  // Even parity: data bits plus parity bit hold an even number of ones.
  assign par_drive = ^tx_word_q;

  tri_buf #(.WIDTH(1)) u_par_buf (
    .in_i  (par_drive),
    .en_i  (drive_en),
    .io_io (par_io)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_parity_err_q <= 1'b0;
    end else begin
      rx_parity_err_q <= capture && ((^bus_io) != (par_io === 1'b1));
    end
  end

  assign rx_parity_err = rx_parity_err_q;
`endif

endmodule

// File: tb/tb_tristate_bus_xcvr.sv
`timescale 1ns/1ps
module tb_tristate_bus_xcvr;

  localparam int W      = 8;
  localparam int TURN   = 2;
  localparam int PERIOD = 4 + TURN;   // acceptance-to-acceptance cycles

  logic         clk      = 1'b0;
  logic         rst_n    = 1'b0;
  logic [W-1:0] tx_data  = '0;
  logic         tx_valid = 1'b0;
  logic         tx_ready;
  logic [W-1:0] rx_data;
  logic         rx_valid;
  logic         oe;

  tri0 [W-1:0]  bus_w;
  tri0          stb_w;

  // Peer: drives data and a high strobe together while peer_en is set.
  logic         peer_en   = 1'b0;
  logic [W-1:0] peer_data = '0;
  assign bus_w = peer_en ? peer_data : {W{1'bz}};
  assign stb_w = peer_en ? 1'b1 : 1'bz;

`ifdef BUS_PARITY_EN
  tri0          par_w;
  logic         peer_par = 1'b0;
  logic         rx_parity_err;
  assign par_w = peer_en ? peer_par : 1'bz;
`endif

  tristate_bus_xcvr #(.WIDTH(W), .TURN_CYCLES(TURN)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .bus_io        (bus_w),
    .stb_io        (stb_w),
`ifdef BUS_PARITY_EN
    .par_io        (par_w),
    .rx_parity_err (rx_parity_err),
`endif
    .oe            (oe)
  );

  always #5 clk = ~clk;

  // --------------------------------------------------------------------------
  // Checking
  // --------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model. A transfer is described only by how many cycles have
  // elapsed since its acceptance: drive on 1..3, strobe on 2, free again at
  // PERIOD. Receive is "first cycle of a visible peer strobe".
  // --------------------------------------------------------------------------
  int           since = -1;          // cycles since acceptance, -1 = free
  logic [W-1:0] m_word = '0;
  logic         m_prev = 1'b0;
  logic         m_rx_valid = 1'b0;
  logic [W-1:0] m_rx_data = '0;
  logic         m_perr = 1'b0;
  bit           accepted = 1'b0;     // model accepted at the last edge
  int           rx_pulses = 0;       // DUT rx_valid pulses observed
  int           dut_acc[$];          // cycles where DUT showed valid&ready

  function automatic bit m_oe();
    return (since >= 1) && (since <= 3);
  endfunction

  task automatic model_reset();
    since      = -1;
    m_prev     = 1'b0;
    m_rx_valid = 1'b0;
    m_rx_data  = '0;
    m_perr     = 1'b0;
    accepted   = 1'b0;
  endtask

  // One clock cycle: check outputs at the falling edge against the model,
  // then advance the model at the rising edge, then leave inputs to caller.
  task automatic run_cycle();
    bit peer_eff;
    bit cap;
    bit acc;
    @(negedge clk);
    check_eq("tx_ready", tx_ready, (since < 0) && !peer_en);
    check_eq("oe", oe, m_oe());
    if (m_oe()) begin
      check_eq("bus", bus_w, m_word);
      check_eq("stb", stb_w, since == 2);
    end
    check_eq("rx_valid", rx_valid, m_rx_valid);
    check_eq("rx_data", rx_data, m_rx_data);
`ifdef BUS_PARITY_EN
    check_eq("rx_parity_err", rx_parity_err, m_perr);
`endif
    if (rx_valid) rx_pulses++;
    if (tx_valid && tx_ready) dut_acc.push_back(cyc);

    @(posedge clk);
    peer_eff   = peer_en && !m_oe();
    acc        = (since < 0) && tx_valid && !peer_eff;
    cap        = peer_eff && !m_prev;
    m_prev     = peer_eff;
    m_rx_valid = cap;
    m_perr     = 1'b0;
    if (cap) begin
      m_rx_data = peer_data;
`ifdef BUS_PARITY_EN
      m_perr = ((^peer_data) != peer_par);
`endif
      $display("cycle %0d: rx capture data=%02h", cyc, peer_data);
    end
    if (acc) begin
      since  = 1;
      m_word = tx_data;
      $display("cycle %0d: tx accept data=%02h", cyc, tx_data);
    end else if (since > 0) begin
      since++;
      if (since >= PERIOD) since = -1;
    end
    accepted = acc;
    cyc++;
    #1;
  endtask

  // Watchdog: the stimulus below is bounded, this only guards against a hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int hold;
    int guard;

    // ---------------- reset state ----------------
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("rst_tx_ready", tx_ready, 1'b0);
      check_eq("rst_oe", oe, 1'b0);
      check_eq("rst_rx_valid", rx_valid, 1'b0);
      check_eq("rst_rx_data", rx_data, '0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ---------------- single transmit A5 ----------------
    tx_data = 8'hA5; tx_valid = 1'b1;
    run_cycle();
    tx_valid = 1'b0;
    for (int i = 0; i < 7; i++) run_cycle();

    // ---------------- receive 3C, single-cycle strobe ----------------
    peer_en = 1'b1; peer_data = 8'h3C;
    rx_pulses = 0;
    run_cycle();
    peer_en = 1'b0;
    for (int i = 0; i < 3; i++) run_cycle();
    check_eq("rx_3c_data", rx_data, 8'h3C);
    check_eq("rx_3c_pulses", rx_pulses, 1);

    // ---------------- strobe held 3 cycles ----------------
    rx_pulses = 0;
    peer_en = 1'b1; peer_data = 8'h5C;
    for (int i = 0; i < 3; i++) run_cycle();
    peer_en = 1'b0;
    for (int i = 0; i < 3; i++) run_cycle();
    check_eq("rx_held_pulses", rx_pulses, 1);
    check_eq("rx_held_data", rx_data, 8'h5C);

    // ---------------- collision: peer 5A vs tx 11 ----------------
    peer_en = 1'b1; peer_data = 8'h5A;
    tx_data = 8'h11; tx_valid = 1'b1;
    run_cycle();
    peer_en = 1'b0;
    for (int i = 0; i < 9; i++) begin
      run_cycle();
      if (accepted) tx_valid = 1'b0;
    end
    check_eq("coll_rx_data", rx_data, 8'h5A);

    // ---------------- back-to-back 01, 02 ----------------
    dut_acc.delete();
    tx_data = 8'h01; tx_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      run_cycle();
      if (accepted) begin
        if (tx_data == 8'h01) tx_data = 8'h02;
        else tx_valid = 1'b0;
      end
    end
    check_eq("b2b_count", dut_acc.size(), 2);
    if (dut_acc.size() >= 2)
      check_eq("b2b_spacing", dut_acc[1] - dut_acc[0], PERIOD);

    // ---------------- randomized traffic ----------------
    hold = 0;
    for (int i = 0; i < 400; i++) begin
      if (!tx_valid || accepted) begin
        tx_valid = ($urandom_range(0, 2) != 0);
        tx_data  = W'($urandom);
      end
      if (m_oe()) begin
        peer_en = 1'b0;
        hold    = 0;
      end else if (hold > 0) begin
        peer_en = 1'b1;
        hold--;
      end else if ($urandom_range(0, 4) == 0) begin
        hold      = $urandom_range(0, 2);
        peer_data = W'($urandom);
`ifdef BUS_PARITY_EN
        peer_par  = 1'($urandom_range(0, 1));
`endif
        peer_en   = 1'b1;
      end else begin
        peer_en = 1'b0;
      end
      run_cycle();
    end
    peer_en = 1'b0; tx_valid = 1'b0;
    for (int i = 0; i < PERIOD + 2; i++) run_cycle();

    // ---------------- reset during STROBE ----------------
    peer_en = 1'b1; peer_data = 8'h99;
    run_cycle();
    peer_en = 1'b0;
    run_cycle();
    tx_data = 8'hC3; tx_valid = 1'b1;
    guard = 0;
    while (since != 2 && guard < 20) begin
      run_cycle();
      if (accepted) tx_valid = 1'b0;
      guard++;
    end
    check_eq("reach_strobe", since, 2);
    check_eq("strobe_oe", oe, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_oe", oe, 1'b0);
    check_eq("midrst_tx_ready", tx_ready, 1'b0);
    check_eq("midrst_rx_valid", rx_valid, 1'b0);
    check_eq("midrst_rx_data", rx_data, '0);
    @(negedge clk);
    check_eq("midrst_oe2", oe, 1'b0);
    rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) run_cycle();

`ifdef BUS_PARITY_EN
    // ---------------- parity ----------------
    peer_en = 1'b1; peer_data = 8'h01; peer_par = 1'b0;
    run_cycle();
    peer_en = 1'b0;
    run_cycle();   // model expects rx_parity_err with rx_valid here
    peer_en = 1'b1; peer_data = 8'h01; peer_par = 1'b1;
    run_cycle();
    peer_en = 1'b0;
    for (int i = 0; i < 3; i++) run_cycle();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
